queue_mp: RTL and testbench

//  Parametrised multi-port circular FIFO for the OoO core. It accepts up to ENQ_PORTS entries and

---
 rtl/queue_mp.sv | 128 ++++++++++++
 tb/tb_queue_mp.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_mp.sv
// Multi-port circular FIFO: up to ENQ_PORTS writes and DEQ_PORTS reads per cycle,
// all-or-nothing enqueue, combinational read with registered pop, optional keep-head flush.
module queue_mp #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned ENQ_PORTS = 2,
    parameter int unsigned DEQ_PORTS = 2,
    parameter int unsigned KEEP_HEAD = 0,
    parameter int unsigned AFULL_LVL = 12,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned EW = $clog2(ENQ_PORTS + 1),
    localparam int unsigned DW = $clog2(DEQ_PORTS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       flush,
    input  logic [EW-1:0]              enq_cnt,
    input  logic [ENQ_PORTS*WIDTH-1:0] enq_data,
    output logic                       enq_ok,
    input  logic [DW-1:0]              deq_cnt,
    output logic [DEQ_PORTS*WIDTH-1:0] deq_data,
    output logic [DEQ_PORTS-1:0]       deq_valid,
    output logic [CW-1:0]              size,
    output logic                       full,
    output logic                       almost_full
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    size_q, size_d;

    logic [EW-1:0]    enq_n;
    logic [DW-1:0]    deq_n;
    logic [CW-1:0]    free_c;
    logic [CW-1:0]    enq_add;
    logic [CW-1:0]    deq_req;
    logic [CW-1:0]    grant;

    // Request clamping, free space from registered size, dequeue grant
    always_comb begin
        enq_n   = (enq_cnt > EW'(ENQ_PORTS)) ? EW'(ENQ_PORTS) : enq_cnt;
        deq_n   = (deq_cnt > DW'(DEQ_PORTS)) ? DW'(DEQ_PORTS) : deq_cnt;
        free_c  = CW'(DEPTH) - size_q;
        enq_ok  = (free_c >= CW'(enq_n));
        enq_add = enq_ok ? CW'(enq_n) : '0;
        deq_req = CW'(deq_n);
        if (stall) begin
            grant = '0;
        end else if (deq_req < size_q) begin
            grant = deq_req;
        end else begin
            grant = size_q;
        end
    end

    // Read lanes: thermometer valid, zeroed data on ungranted lanes
    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        for (int unsigned i = 0; i < DEQ_PORTS; i++) begin
            deq_valid[i] = (CW'(i) < grant);
            if (deq_valid[i]) begin
                deq_data[i*WIDTH +: WIDTH] = mem_q[head_q + PW'(i)];
            end
        end
    end

    // Next state: normal enqueue/pop, with flush overriding both
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q + PW'(grant);
        tail_d = tail_q;
        size_d = size_q + enq_add - grant;

        if (enq_ok) begin
            for (int unsigned i = 0; i < ENQ_PORTS; i++) begin
                if (EW'(i) < enq_n) begin
                    mem_d[tail_q + PW'(i)] = enq_data[i*WIDTH +: WIDTH];
                end
            end
            tail_d = tail_q + PW'(enq_n);
        end

        if (flush) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_d[j] = '0;
            end
            head_d = '0;
            tail_d = '0;
            size_d = '0;
            if ((KEEP_HEAD != 0) && (size_q != '0)) begin
                mem_d[0] = mem_q[head_q];
                tail_d   = PW'(1);
                size_d   = CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_q[j] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            size_q <= '0;
        end else begin
            for (int unsigned j = 0; j < DEPTH; j++) begin
                mem_q[j] <= mem_d[j];
            end
            head_q <= head_d;
            tail_q <= tail_d;
            size_q <= size_d;
        end
    end

    // Status flags depend only on registered occupancy
    always_comb begin
        size        = size_q;
        full        = (size_q == CW'(DEPTH));
        almost_full = (size_q >= CW'(AFULL_LVL));
    end

endmodule

// File: tb/tb_queue_mp.sv
// Directed self-checking bench for queue_mp (default and KEEP_HEAD=1 instances share stimulus).
module tb_queue_mp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  enq_cnt = '0;
    logic [63:0] enq_data = '0;
    logic [1:0]  deq_cnt = '0;

    logic        enq_ok, full, almost_full;
    logic [63:0] deq_data;
    logic [1:0]  deq_valid;
    logic [4:0]  size;

    logic        enq_ok_k, full_k, almost_full_k;
    logic [63:0] deq_data_k;
    logic [1:0]  deq_valid_k;
    logic [4:0]  size_k;

    int n_tests = 0;
    int n_fail  = 0;

    queue_mp dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .enq_cnt(enq_cnt), .enq_data(enq_data), .enq_ok(enq_ok),
        .deq_cnt(deq_cnt), .deq_data(deq_data), .deq_valid(deq_valid),
        .size(size), .full(full), .almost_full(almost_full)
    );

    queue_mp #(.KEEP_HEAD(1)) dut_k (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .enq_cnt(enq_cnt), .enq_data(enq_data), .enq_ok(enq_ok_k),
        .deq_cnt(deq_cnt), .deq_data(deq_data_k), .deq_valid(deq_valid_k),
        .size(size_k), .full(full_k), .almost_full(almost_full_k)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] e, input logic [31:0] a0, input logic [31:0] a1,
                         input logic [1:0] d, input logic st, input logic fl);
        enq_cnt  = e;
        enq_data = {a1, a0};
        deq_cnt  = d;
        stall    = st;
        flush    = fl;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(2'd2, 32'hDEAD, 32'hBEEF, 2'd2, 1'b0, 1'b0);
        n_tests++; if (size !== 5'd0) begin n_fail++; $display("FAIL reset_size: got %0d want 0", size); end
        n_tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got full=%b af=%b want 0 0", full, almost_full); end
        n_tests++; if (enq_ok !== 1'b1) begin n_fail++; $display("FAIL reset_enq_ok: got %b want 1", enq_ok); end
        n_tests++; if (deq_valid !== 2'b00 || deq_data !== 64'h0) begin n_fail++; $display("FAIL reset_deq: got v=%b d=%h want 00 0", deq_valid, deq_data); end
        n_tests++; if (size_k !== 5'd0) begin n_fail++; $display("FAIL reset_size_k: got %0d want 0", size_k); end
        @(negedge clk);
        reset = 1'b1;
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        cyc();
    endtask

    task automatic test_basic();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(2'd2, 32'h10, 32'h11, 2'd0, 1'b0, 1'b0);
            cyc();
        end
        n_tests++; if (size !== 5'd6) begin n_fail++; $display("FAIL basic_size: got %0d want 6", size); end
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        n_tests++; if (deq_valid !== 2'b11) begin n_fail++; $display("FAIL basic_valid: got %b want 11", deq_valid); end
        n_tests++; if (deq_data !== {32'h11, 32'h10}) begin n_fail++; $display("FAIL basic_data: got %h want %h", deq_data, {32'h11, 32'h10}); end
        cyc();
        n_tests++; if (size !== 5'd4) begin n_fail++; $display("FAIL basic_size_pop: got %0d want 4", size); end
        // enq_cnt=3 clamps to 2
        drive(2'd3, 32'h20, 32'h21, 2'd0, 1'b0, 1'b0);
        cyc();
        n_tests++; if (size !== 5'd6) begin n_fail++; $display("FAIL basic_clamp: got %0d want 6", size); end
    endtask

    task automatic test_full();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(2'd2, 32'h100 + 32'(2*k), 32'h101 + 32'(2*k), 2'd0, 1'b0, 1'b0);
            if (k == 5) begin
                n_tests++; if (almost_full !== 1'b0) begin n_fail++; $display("FAIL full_af10: got %b want 0", almost_full); end
            end
            if (k == 6) begin
                n_tests++; if (almost_full !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL full_af12: got af=%b full=%b want 1 0", almost_full, full); end
            end
            cyc();
        end
        n_tests++; if (size !== 5'd16 || full !== 1'b1 || almost_full !== 1'b1) begin n_fail++; $display("FAIL full_16: got size=%0d full=%b af=%b want 16 1 1", size, full, almost_full); end
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        n_tests++; if (enq_ok !== 1'b1) begin n_fail++; $display("FAIL full_enq0: got %b want 1", enq_ok); end
        drive(2'd1, 32'h1FF, 32'h0, 2'd1, 1'b0, 1'b0);
        n_tests++; if (enq_ok !== 1'b0) begin n_fail++; $display("FAIL full_enq_ok: got %b want 0", enq_ok); end
        n_tests++; if (deq_valid !== 2'b01 || deq_data[31:0] !== 32'h100) begin n_fail++; $display("FAIL full_deq: got v=%b d0=%h want 01 100", deq_valid, deq_data[31:0]); end
        cyc();
        n_tests++; if (size !== 5'd15 || full !== 1'b0) begin n_fail++; $display("FAIL full_15: got size=%0d full=%b want 15 0", size, full); end
        drive(2'd3, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        n_tests++; if (enq_ok !== 1'b0) begin n_fail++; $display("FAIL full_enq2_at15: got %b want 0", enq_ok); end
        drive(2'd1, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        n_tests++; if (enq_ok !== 1'b1) begin n_fail++; $display("FAIL full_enq1_at15: got %b want 1", enq_ok); end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int r = 0; r < 15; r++) begin
            drive(2'd1, 32'h200 + 32'(r), 32'h0, 2'd0, 1'b0, 1'b0);
            cyc();
            drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
            n_tests++; if (deq_valid !== 2'b01 || deq_data[31:0] !== 32'h200 + 32'(r)) begin n_fail++; $display("FAIL wrap_round%0d: got v=%b d0=%h want 01 %h", r, deq_valid, deq_data[31:0], 32'h200 + 32'(r)); end
            cyc();
        end
        drive(2'd2, 32'h2A0, 32'h2A1, 2'd0, 1'b0, 1'b0);
        cyc();
        n_tests++; if (size !== 5'd2) begin n_fail++; $display("FAIL wrap_size: got %0d want 2", size); end
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        n_tests++; if (deq_valid !== 2'b11 || deq_data !== {32'h2A1, 32'h2A0}) begin n_fail++; $display("FAIL wrap_data: got v=%b d=%h want 11 %h", deq_valid, deq_data, {32'h2A1, 32'h2A0}); end
        cyc();
        n_tests++; if (size !== 5'd0) begin n_fail++; $display("FAIL wrap_empty: got %0d want 0", size); end
    endtask

    task automatic test_partial_stall();
        do_reset();
        drive(2'd1, 32'h300, 32'h0, 2'd0, 1'b0, 1'b0);
        cyc();
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        n_tests++; if (deq_valid !== 2'b01 || deq_data !== {32'h0, 32'h300}) begin n_fail++; $display("FAIL partial_deq: got v=%b d=%h want 01 %h", deq_valid, deq_data, {32'h0, 32'h300}); end
        cyc();
        n_tests++; if (size !== 5'd0) begin n_fail++; $display("FAIL partial_size: got %0d want 0", size); end
        n_tests++; if (deq_valid !== 2'b00) begin n_fail++; $display("FAIL empty_deq: got %b want 00", deq_valid); end
        cyc();
        n_tests++; if (size !== 5'd0) begin n_fail++; $display("FAIL empty_size: got %0d want 0", size); end
        drive(2'd2, 32'h310, 32'h311, 2'd0, 1'b0, 1'b0);
        cyc();
        drive(2'd2, 32'h312, 32'h313, 2'd0, 1'b0, 1'b0);
        cyc();
        drive(2'd1, 32'h314, 32'h0, 2'd2, 1'b1, 1'b0);
        n_tests++; if (deq_valid !== 2'b00 || deq_data !== 64'h0 || enq_ok !== 1'b1) begin n_fail++; $display("FAIL stall_comb: got v=%b d=%h ok=%b want 00 0 1", deq_valid, deq_data, enq_ok); end
        cyc();
        n_tests++; if (size !== 5'd5) begin n_fail++; $display("FAIL stall_size: got %0d want 5", size); end
        // deq_cnt=3 clamps to 2, concurrent with a 2-entry enqueue
        drive(2'd2, 32'h315, 32'h316, 2'd3, 1'b0, 1'b0);
        n_tests++; if (deq_valid !== 2'b11 || deq_data !== {32'h311, 32'h310}) begin n_fail++; $display("FAIL b2b_data: got v=%b d=%h want 11 %h", deq_valid, deq_data, {32'h311, 32'h310}); end
        cyc();
        n_tests++; if (size !== 5'd5) begin n_fail++; $display("FAIL b2b_size: got %0d want 5", size); end
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        n_tests++; if (deq_data !== {32'h313, 32'h312}) begin n_fail++; $display("FAIL b2b_order: got %h want %h", deq_data, {32'h313, 32'h312}); end
        cyc();
        n_tests++; if (size !== 5'd3) begin n_fail++; $display("FAIL b2b_size2: got %0d want 3", size); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(2'd2, 32'h50 + 32'(2*k), 32'h51 + 32'(2*k), 2'd0, 1'b0, 1'b0);
            cyc();
        end
        drive(2'd1, 32'h58, 32'h0, 2'd0, 1'b0, 1'b0);
        cyc();
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        cyc();
        cyc();
        drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        cyc();
        n_tests++; if (size_k !== 5'd4 || size !== 5'd4) begin n_fail++; $display("FAIL flush_setup: got %0d/%0d want 4/4", size, size_k); end
        drive(2'd2, 32'hAA, 32'hBB, 2'd0, 1'b0, 1'b1);
        n_tests++; if (enq_ok !== 1'b1) begin n_fail++; $display("FAIL flush_enq_ok: got %b want 1", enq_ok); end
        cyc();
        n_tests++; if (size_k !== 5'd1) begin n_fail++; $display("FAIL flush_keep_size: got %0d want 1", size_k); end
        n_tests++; if (size !== 5'd0) begin n_fail++; $display("FAIL flush_clear_size: got %0d want 0", size); end
        drive(2'd0, 32'h0, 32'h0, 2'd1, 1'b0, 1'b0);
        n_tests++; if (deq_valid_k !== 2'b01 || deq_data_k !== {32'h0, 32'h55}) begin n_fail++; $display("FAIL flush_keep_data: got v=%b d=%h want 01 %h", deq_valid_k, deq_data_k, {32'h0, 32'h55}); end
        n_tests++; if (deq_valid !== 2'b00 || deq_data !== 64'h0) begin n_fail++; $display("FAIL flush_clear_deq: got v=%b d=%h want 00 0", deq_valid, deq_data); end
        cyc();
        n_tests++; if (size_k !== 5'd0) begin n_fail++; $display("FAIL flush_keep_pop: got %0d want 0", size_k); end
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1);
        cyc();
        n_tests++; if (size_k !== 5'd0) begin n_fail++; $display("FAIL flush_keep_empty: got %0d want 0", size_k); end
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(2'd2, 32'h601, 32'h602, 2'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        n_tests++; if (size !== 5'd4) begin n_fail++; $display("FAIL midrst_pre: got %0d want 4", size); end
        drive(2'd2, 32'h603, 32'h604, 2'd2, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        n_tests++; if (size !== 5'd0 || size_k !== 5'd0) begin n_fail++; $display("FAIL midrst_size: got %0d/%0d want 0/0", size, size_k); end
        n_tests++; if (deq_valid !== 2'b00 || deq_data !== 64'h0) begin n_fail++; $display("FAIL midrst_deq: got v=%b d=%h want 00 0", deq_valid, deq_data); end
        drive(2'd0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        cyc();
        drive(2'd1, 32'h600, 32'h0, 2'd0, 1'b0, 1'b0);
        cyc();
        drive(2'd0, 32'h0, 32'h0, 2'd2, 1'b0, 1'b0);
        n_tests++; if (deq_valid !== 2'b01 || deq_data !== {32'h0, 32'h600}) begin n_fail++; $display("FAIL midrst_first: got v=%b d=%h want 01 %h", deq_valid, deq_data, {32'h0, 32'h600}); end
        cyc();
        n_tests++; if (size !== 5'd0) begin n_fail++; $display("FAIL midrst_after: got %0d want 0", size); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #2;
        test_reset();
        test_basic();
        test_full();
        test_wrap();
        test_partial_stall();
        test_flush();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
